homenc_seq_ctrl: RTL and testbench
==================================

# homenc_seq_ctrl

Instruction sequencer for the homomorphic-encryption coprocessor. Holds a short CPU-loaded program of coprocessor operations (instruction code, modulus bank, lift memory selects) and issues them one at a time, inserting instruction-0 reset gaps between operations and waiting on the coprocessor `done` before advancing. It also arbitrates CPU memory access: `cpu_interrupt` is granted only while no program is running.

## Interface

Parameters:
- `DEPTH`, 16: program entries; power of two.
- `RST_CYCLES`, 2: cycles of instruction 0 driven before each operation; must be ≥1.
- `DONE_MASK`, 4: cycles after an operation starts during which `done` is ignored.
- `TIMEOUT`, 2^20: maximum EXEC cycles per operation before abort.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `prog_wr_en` in 1: program write strobe; accepted only in IDLE.
- `prog_wr_addr` in log2(DEPTH): entry index.
- `prog_wr_data` in 25: {instr[24:17], modulus_sel[16], rdM0[15:12], rdM1[11:8], wtM0[7:4], wtM1[3:0]}.
- `prog_len` in log2(DEPTH)+1: number of entries to run; sampled on `start`.
- `start` in 1: single-cycle run request.
- `abort` in 1: stop the running program.
- `cpu_req` in 1: CPU memory-access request.
- `cpu_interrupt` out 1: granted CPU access, forwarded to the coprocessor.
- `instruction` out 8: coprocessor instruction.
- `modulus_sel` out 1.
- `rdM0`, `rdM1`, `wtM0`, `wtM1` out 4 each.
- `done` in 1: coprocessor completion.
- `busy` out 1: high when not in IDLE.
- `pc` out log2(DEPTH): current entry index.
- `seq_done` out 1: one-cycle pulse when a program completes normally.
- `error` out 1: sticky timeout flag, cleared by the next accepted `start`.

## Operation

- States: IDLE, CLR, EXEC.
- **IDLE**
  - `instruction`=0.
  - `cpu_interrupt` = `cpu_req`, registered.
  - `start` with `prog_len`=0: stay in IDLE, pulse `seq_done` next cycle.
  - `start` with `prog_len`>0: latch `prog_len`, set `pc`=0, clear `error`, go to CLR.
- **CLR**
  - `instruction`=0 for RST_CYCLES cycles. This holds the RLWE cores in reset.
  - `cpu_interrupt`=0.
  - Then go to EXEC.
- **EXEC**
  - Outputs are driven from entry[`pc`]. `instruction`, `modulus_sel` and the M selects are constant for the whole operation.
  - A cycle counter starts at 0. `done` is ignored while the counter < DONE_MASK.
  - On a qualified `done`: if `pc`=len−1, go to IDLE and pulse `seq_done`; otherwise increment `pc` and go to CLR.
  - If the counter reaches TIMEOUT: set `error`, go to IDLE, no `seq_done`.
- **abort** in CLR or EXEC: go to IDLE next cycle, no `seq_done`, `error` unchanged. `abort` in IDLE has no effect.
- **Priority:** `abort` > timeout > qualified `done`.
- `start` or `prog_wr_en` while `busy` is ignored; program contents are unchanged.
- An entry with instr=0 is executed normally; the program relies on `done`/timeout to finish it.
- The CPU is never granted mid-program. A `cpu_req` that is high when the sequencer returns to IDLE is granted the cycle after IDLE is entered.

## Timing

- All outputs are registered.
- Reset values: `instruction`=0, `modulus_sel`=0, all M selects=0, `cpu_interrupt`=0, `busy`=0, `pc`=0, `seq_done`=0, `error`=0. State resets to IDLE.
- `start` at cycle t:
  - `busy`=1 and `instruction`=0 at t+1.
  - First op instruction at t+1+RST_CYCLES.
- Qualified `done` at cycle d:
  - Non-final op: `instruction`=0 at d+1.
  - Final op: IDLE, `busy`=0 and `seq_done`=1 at d+1.
- The program RAM has 1-cycle read latency. Entry `pc` is fetched during CLR, so EXEC outputs are valid on the first EXEC cycle.
- `cpu_interrupt` latency is 1 cycle from `cpu_req` in IDLE. It drops to 0 the same edge `busy` rises.
- Reset asserted mid-program returns all outputs to reset values immediately. Program RAM contents are not cleared.

## Structure

- Shared header `homenc_seq_defs.vh`:
  - state encodings;
  - program-word field offsets/widths (INSTR_MSB … WTM1_LSB);
  - instruction code 0 (`INSTR_IDLE`).
- Sub-module `seq_prog_ram`: DEPTH×25 simple dual-port, synchronous write, registered read; maps to distributed RAM.
- Top: FSM, `pc`/len registers, EXEC cycle counter (width log2(TIMEOUT)+1), CLR counter, grant logic.

## Test plan

- Load 3 entries (instr 1,2,3; modulus_sel 0,1,0), `start` with len=3, `done` pulsed 10 cycles into each EXEC → instruction sequence 0,0,1,0,0,2,0,0,3,0; one `seq_done`; `busy` low after.
- `done` held high continuously, len=2 → each op lasts exactly DONE_MASK+1 EXEC cycles; stale `done` never skips an op.
- TIMEOUT=64, `done` never asserted → `error`=1 at EXEC cycle 64, IDLE, no `seq_done`; next `start` clears `error`.
- `abort` during second op of 4; `cpu_req` held high throughout → `cpu_interrupt`=0 while busy, IDLE next cycle, `cpu_interrupt`=1 one cycle later.
- `prog_wr_en` and `start` while busy → RAM unchanged (read back), run continues unperturbed; `start` with len=0 → `seq_done` only, `busy` stays 0.
- `rst_n` asserted in EXEC → outputs 0 immediately; after release, rerun without reload executes the stored program.

Source files
------------

// File: rtl/homenc_seq_ctrl_pkg.sv
// Shared definitions for the HE coprocessor sequencer: state codes, program-word layout, idle instruction.
// Pure declarations; no timing or flow control.
package homenc_seq_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CLR  = 2'd1;
  localparam logic [1:0] ST_EXEC = 2'd2;

  localparam int PROG_W     = 25;
  localparam int INSTR_MSB  = 24;
  localparam int INSTR_LSB  = 17;
  localparam int MODSEL_BIT = 16;
  localparam int RDM0_MSB   = 15;
  localparam int RDM0_LSB   = 12;
  localparam int RDM1_MSB   = 11;
  localparam int RDM1_LSB   = 8;
  localparam int WTM0_MSB   = 7;
  localparam int WTM0_LSB   = 4;
  localparam int WTM1_MSB   = 3;
  localparam int WTM1_LSB   = 0;

  localparam logic [7:0] INSTR_IDLE = 8'h00;

  typedef struct packed {
    logic [7:0] instr;
    logic       modulus_sel;
    logic [3:0] rdm0;
    logic [3:0] rdm1;
    logic [3:0] wtm0;
    logic [3:0] wtm1;
  } prog_word_t;

  function automatic prog_word_t unpack_word(input logic [PROG_W-1:0] w);
    prog_word_t r;
    r.instr       = w[INSTR_MSB:INSTR_LSB];
    r.modulus_sel = w[MODSEL_BIT];
    r.rdm0        = w[RDM0_MSB:RDM0_LSB];
    r.rdm1        = w[RDM1_MSB:RDM1_LSB];
    r.wtm0        = w[WTM0_MSB:WTM0_LSB];
    r.wtm1        = w[WTM1_MSB:WTM1_LSB];
    return r;
  endfunction

  // Word driven whenever no operation is executing: holds the RLWE cores in reset.
  function automatic prog_word_t idle_word();
    prog_word_t r;
    r       = '0;
    r.instr = INSTR_IDLE;
    return r;
  endfunction

endpackage

// File: rtl/seq_prog_ram.sv
// DEPTH x 25 simple dual-port program store: synchronous write, registered read (1-cycle latency).
// No flow control; the write port is gated by the caller.
module seq_prog_ram
  import homenc_seq_ctrl_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [PROG_W-1:0]        wr_data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [PROG_W-1:0]        rd_data_o
);

  logic [PROG_W-1:0] mem_q [DEPTH];
  logic [PROG_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/homenc_seq_ctrl.sv
// Issues a CPU-loaded program to the HE coprocessor: RST_CYCLES of instruction 0, then the op until a masked done.
// start-to-busy 1 cycle; ops advance only on qualified done, abort or timeout; CPU granted only while idle.
module homenc_seq_ctrl
  import homenc_seq_ctrl_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int RST_CYCLES = 2,
  parameter int DONE_MASK  = 4,
  parameter int TIMEOUT    = 1 << 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     prog_wr_en,
  input  logic [$clog2(DEPTH)-1:0] prog_wr_addr,
  input  logic [24:0]              prog_wr_data,
  input  logic [$clog2(DEPTH):0]   prog_len,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     cpu_req,
  output logic                     cpu_interrupt,
  output logic [7:0]               instruction,
  output logic                     modulus_sel,
  output logic [3:0]               rdM0,
  output logic [3:0]               rdM1,
  output logic [3:0]               wtM0,
  output logic [3:0]               wtM1,
  input  logic                     done,
  output logic                     busy,
  output logic [$clog2(DEPTH)-1:0] pc,
  output logic                     seq_done,
  output logic                     error
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  logic [1:0]     state_q, state_d;
  logic [AW-1:0]  pc_q, pc_d;
  logic [AW:0]    len_q, len_d;
  logic [CW-1:0]  exec_cnt_q, exec_cnt_d;
  logic [RW-1:0]  clr_cnt_q, clr_cnt_d;
  logic           err_q, err_d;
  logic           seq_done_q, seq_done_d;
  logic           busy_q, busy_d;
  logic           cpu_int_q, cpu_int_d;
  prog_word_t     word_q, word_d;

  logic [PROG_W-1:0] ram_rdata;
  prog_word_t        ram_word;
  logic              ram_we;
  logic              last_op;
  logic              timeout_hit;
  logic              done_qual;

  assign ram_we = prog_wr_en && (state_q == ST_IDLE);

  // Read address follows the next pc so the entry is already registered during the first CLR cycle.
  seq_prog_ram #(.DEPTH(DEPTH)) u_ram (
    .clk       (clk),
    .wr_en_i   (ram_we),
    .wr_addr_i (prog_wr_addr),
    .wr_data_i (prog_wr_data),
    .rd_addr_i (pc_d),
    .rd_data_o (ram_rdata)
  );

  assign ram_word    = unpack_word(ram_rdata);
  assign last_op     = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));
  assign timeout_hit = (exec_cnt_q == CW'(TIMEOUT - 1));
  assign done_qual   = done && (exec_cnt_q >= CW'(DONE_MASK));

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    len_d      = len_q;
    exec_cnt_d = exec_cnt_q;
    clr_cnt_d  = clr_cnt_q;
    err_d      = err_q;
    seq_done_d = 1'b0;
    cpu_int_d  = 1'b0;
    word_d     = word_q;

    case (state_q)
      ST_IDLE: begin
        word_d    = idle_word();
        cpu_int_d = cpu_req;
        if (start) begin
          if (prog_len == '0) begin
            seq_done_d = 1'b1;
          end else begin
            state_d   = ST_CLR;
            pc_d      = '0;
            // Lengths beyond the store would never reach a final entry; clamp them.
            len_d     = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
            err_d     = 1'b0;
            clr_cnt_d = '0;
            cpu_int_d = 1'b0;
          end
        end
      end

      ST_CLR: begin
        word_d = idle_word();
        if (abort) begin
          state_d = ST_IDLE;
        end else if (clr_cnt_q == RW'(RST_CYCLES - 1)) begin
          state_d    = ST_EXEC;
          exec_cnt_d = '0;
          word_d     = ram_word;
        end else begin
          clr_cnt_d = clr_cnt_q + RW'(1);
        end
      end

      ST_EXEC: begin
        exec_cnt_d = exec_cnt_q + CW'(1);
        if (abort) begin
          state_d = ST_IDLE;
          word_d  = idle_word();
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          word_d  = idle_word();
        end else if (done_qual) begin
          word_d = idle_word();
          if (last_op) begin
            state_d    = ST_IDLE;
            seq_done_d = 1'b1;
          end else begin
            state_d   = ST_CLR;
            pc_d      = pc_q + AW'(1);
            clr_cnt_d = '0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        word_d  = idle_word();
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      len_q      <= '0;
      exec_cnt_q <= '0;
      clr_cnt_q  <= '0;
      err_q      <= 1'b0;
      seq_done_q <= 1'b0;
      busy_q     <= 1'b0;
      cpu_int_q  <= 1'b0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      len_q      <= len_d;
      exec_cnt_q <= exec_cnt_d;
      clr_cnt_q  <= clr_cnt_d;
      err_q      <= err_d;
      seq_done_q <= seq_done_d;
      busy_q     <= busy_d;
      cpu_int_q  <= cpu_int_d;
      word_q     <= word_d;
    end
  end

  assign cpu_interrupt = cpu_int_q;
  assign instruction   = word_q.instr;
  assign modulus_sel   = word_q.modulus_sel;
  assign rdM0          = word_q.rdm0;
  assign rdM1          = word_q.rdm1;
  assign wtM0          = word_q.wtm0;
  assign wtM1          = word_q.wtm1;
  assign busy          = busy_q;
  assign pc            = pc_q;
  assign seq_done      = seq_done_q;
  assign error         = err_q;

endmodule

// File: tb/tb_homenc_seq_ctrl.sv
// Randomized bench for homenc_seq_ctrl: per-op timeline model (CLR gap, EXEC with masked done) drives every check.
module tb_homenc_seq_ctrl;

  localparam int DEPTH = 16;
  localparam int RSTC  = 2;
  localparam int DMASK = 4;
  localparam int TMO   = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        prog_wr_en;
  logic [3:0]  prog_wr_addr;
  logic [24:0] prog_wr_data;
  logic [4:0]  prog_len;
  logic        start, abort, cpu_req, done;
  logic        cpu_interrupt, modulus_sel, busy, seq_done, error;
  logic [7:0]  instruction;
  logic [3:0]  rdM0, rdM1, wtM0, wtM1, pc;

  int n_vec = 0;
  int n_err = 0;
  logic [24:0] model_mem [DEPTH];

  always #5 clk = ~clk;

  homenc_seq_ctrl #(.DEPTH(DEPTH), .RST_CYCLES(RSTC), .DONE_MASK(DMASK), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .prog_wr_en(prog_wr_en), .prog_wr_addr(prog_wr_addr),
    .prog_wr_data(prog_wr_data), .prog_len(prog_len), .start(start), .abort(abort),
    .cpu_req(cpu_req), .cpu_interrupt(cpu_interrupt), .instruction(instruction),
    .modulus_sel(modulus_sel), .rdM0(rdM0), .rdM1(rdM1), .wtM0(wtM0), .wtM1(wtM1),
    .done(done), .busy(busy), .pc(pc), .seq_done(seq_done), .error(error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input int addr, input logic [24:0] data);
    prog_wr_en   = 1'b1;
    prog_wr_addr = 4'(addr);
    prog_wr_data = data;
    @(negedge clk);
    prog_wr_en = 1'b0;
    model_mem[addr] = data;
  endtask

  task automatic chk_idle(input string tag, input logic exp_sd, input logic exp_err);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " instr"}, instruction, 0);
    chk({tag, " seq_done"}, seq_done, exp_sd);
    chk({tag, " error"}, error, exp_err);
    chk({tag, " cpu_int"}, cpu_interrupt, 0);
  endtask

  task automatic chk_exec(input string tag, input int k);
    logic [24:0] w;
    w = model_mem[k];
    chk({tag, " ex instr"}, instruction, w[24:17]);
    chk({tag, " ex modsel"}, modulus_sel, w[16]);
    chk({tag, " ex rdM0"}, rdM0, w[15:12]);
    chk({tag, " ex rdM1"}, rdM1, w[11:8]);
    chk({tag, " ex wtM0"}, wtM0, w[7:4]);
    chk({tag, " ex wtM1"}, wtM1, w[3:0]);
    chk({tag, " ex pc"}, pc, k);
    chk({tag, " ex busy"}, busy, 1);
    chk({tag, " ex cpu_int"}, cpu_interrupt, 0);
  endtask

  // mode: >=0 done pulse at that EXEC cycle, -1 done held high, -2 random, -3 done never asserted.
  task automatic run_prog(input string tag, input int len, input int mode,
                          input int abort_op, input int abort_e, input bit poke);
    int  e, dly;
    bit  qual;
    prog_len = 5'(len);
    start    = 1'b1;
    if (mode == -1) done = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < len; k++) begin
      for (int c = 0; c < RSTC; c++) begin
        chk({tag, " clr instr"}, instruction, 0);
        chk({tag, " clr busy"}, busy, 1);
        chk({tag, " clr pc"}, pc, k);
        chk({tag, " clr cpu_int"}, cpu_interrupt, 0);
        chk({tag, " clr error"}, error, 0);
        chk({tag, " clr seq_done"}, seq_done, 0);
        if (poke && c == 0) begin
          prog_wr_en   = 1'b1;
          prog_wr_addr = 4'(k);
          prog_wr_data = ~model_mem[k];
          start        = 1'b1;
          prog_len     = 5'd1;
        end
        @(negedge clk);
        prog_wr_en = 1'b0;
        start      = 1'b0;
      end
      dly = (mode >= 0) ? mode : int'($urandom_range(DMASK, DMASK + 8));
      e = 0;
      forever begin
        chk_exec(tag, k);
        if (mode == -2)
          done = (e == dly) || (e < DMASK && $urandom_range(0, 1) == 1);
        else if (mode >= 0)
          done = (e == dly);
        if (k == abort_op && e == abort_e) begin
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          done  = 1'b0;
          chk_idle({tag, " abort"}, 0, 0);
          return;
        end
        qual = done && e >= DMASK && e != TMO - 1;
        @(negedge clk);
        if (mode != -1) done = 1'b0;
        if (qual) break;
        e++;
        if (e == TMO) begin
          chk_idle({tag, " timeout"}, 0, 1);
          return;
        end
      end
    end
    done = 1'b0;
    chk_idle({tag, " end"}, 1, 0);
    @(negedge clk);
    chk({tag, " seq_done one pulse"}, seq_done, 0);
  endtask

  initial begin
    rst_n = 1'b0; prog_wr_en = 1'b0; prog_wr_addr = '0; prog_wr_data = '0;
    prog_len = '0; start = 1'b0; abort = 1'b0; cpu_req = 1'b0; done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst instr", instruction, 0);
    chk("rst busy", busy, 0);
    chk("rst pc", pc, 0);
    chk("rst cpu_int", cpu_interrupt, 0);
    chk("rst seq_done", seq_done, 0);
    chk("rst error", error, 0);
    chk("rst sel", {modulus_sel, rdM0, rdM1, wtM0, wtM1}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed three-op program, done 10 cycles into each EXEC.
    load(0, {8'd1, 1'b0, 16'h1234});
    load(1, {8'd2, 1'b1, 16'h5678});
    load(2, {8'd3, 1'b0, 16'h9abc});
    run_prog("seq3", 3, 10, -1, 0, 0);

    // Grant latency in IDLE.
    cpu_req = 1'b1;
    @(negedge clk);
    chk("grant on", cpu_interrupt, 1);
    cpu_req = 1'b0;
    @(negedge clk);
    chk("grant off", cpu_interrupt, 0);

    // Reset asserted in EXEC of op 0, then rerun the stored program.
    prog_len = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (RSTC + 1) @(negedge clk);
    chk("pre-rst instr", instruction, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst instr", instruction, 0);
    chk("midrst busy", busy, 0);
    chk("midrst sel", {modulus_sel, rdM0, rdM1, wtM0, wtM1}, 0);
    chk("midrst pc", pc, 0);
    chk("midrst flags", {cpu_interrupt, seq_done, error}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_prog("rerun", 3, -2, -1, 0, 0);

    run_prog("hold", 2, -1, -1, 0, 0);

    // Writes and starts while busy must not disturb the run or the store.
    run_prog("poke", 3, 6, -1, 0, 1);
    run_prog("readback", 3, -2, -1, 0, 0);

    prog_len = 5'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("len0 seq_done", seq_done, 1);
    chk("len0 busy", busy, 0);
    @(negedge clk);
    chk("len0 pulse", seq_done, 0);
    chk("len0 busy2", busy, 0);

    run_prog("timeout", 1, -3, -1, 0, 0);
    @(negedge clk);
    chk("error sticky", error, 1);
    run_prog("after_to", 2, -2, -1, 0, 0);

    // Abort in second op of four with CPU request pending throughout.
    for (int i = 0; i < 4; i++) load(i, 25'($urandom));
    cpu_req = 1'b1;
    run_prog("abort", 4, 8, 1, 3, 0);
    @(negedge clk);
    chk("abort grant", cpu_interrupt, 1);
    chk("abort busy", busy, 0);
    cpu_req = 1'b0;
    @(negedge clk);

    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < DEPTH; i++) load(i, 25'($urandom));
      cpu_req = 1'($urandom_range(0, 1));
      run_prog("rand", int'($urandom_range(1, DEPTH)), -2, -1, 0, 0);
      cpu_req = 1'b0;
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
